driver_motor_paso: RTL and testbench

DRIVER_MOTOR_PASO -- requirements
Module: driver_motor_paso

---
 rtl/driver_motor_paso.sv | 106 ++++++++++
 tb/tb_driver_motor_paso.sv | 130 +++++++++++++
 2 files changed

// File: rtl/driver_motor_paso.sv
// rtl/driver_motor_paso.sv - stepper motor driver: prescaled step ticks, coil phase sequencer, saturating position.
// Optional MEDIO_PASO_EN selects the 8-entry half-step sequence instead of the 4-entry full-step one.
module driver_motor_paso #(
    parameter logic [15:0] DIV     = 16'd50000,
    parameter logic [15:0] POS_MAX = 16'd3599,
    parameter logic [15:0] POS_INI = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        habilitar,
    input  logic [1:0]  s_in,
    output logic [3:0]  fases,
    output logic [15:0] posicion,
    output logic        paso,
    output logic        lim_max,
    output logic        lim_min
);

`ifdef MEDIO_PASO_EN
    localparam int IDX_W = 3;
`else
    localparam int IDX_W = 2;
`endif

    logic [15:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      pos_q, pos_d;
    logic [3:0]       fases_q, fases_d;
    logic             paso_q, paso_d;
    logic             tick;

    // Sequence index wraps naturally through the index width (N = 2**IDX_W).
    function automatic logic [3:0] patron(input logic [IDX_W-1:0] i);
        patron = 4'b0000;
`ifdef MEDIO_PASO_EN
        case (i)
            3'd0: patron = 4'b0001;
            3'd1: patron = 4'b0011;
            3'd2: patron = 4'b0010;
            3'd3: patron = 4'b0110;
            3'd4: patron = 4'b0100;
            3'd5: patron = 4'b1100;
            3'd6: patron = 4'b1000;
            3'd7: patron = 4'b1001;
        endcase
`else
        case (i)
            2'd0: patron = 4'b0011;
            2'd1: patron = 4'b0110;
            2'd2: patron = 4'b1100;
            2'd3: patron = 4'b1001;
        endcase
`endif
    endfunction

    assign tick = habilitar && (cnt_q == DIV - 16'd1);

    always_comb begin
        cnt_d  = 16'd0;
        idx_d  = idx_q;
        pos_d  = pos_q;
        paso_d = 1'b0;

        if (habilitar && !tick) begin
            cnt_d = cnt_q + 16'd1;
        end

        // Direction is only looked at on the tick; 10 falls through as stop.
        if (tick) begin
            if (s_in == 2'b01 && pos_q < POS_MAX) begin
                idx_d  = idx_q + 1'b1;
                pos_d  = pos_q + 16'd1;
                paso_d = 1'b1;
            end else if (s_in == 2'b11 && pos_q > 16'd0) begin
                idx_d  = idx_q - 1'b1;
                pos_d  = pos_q - 16'd1;
                paso_d = 1'b1;
            end
        end

        fases_d = habilitar ? patron(idx_d) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 16'd0;
            idx_q   <= '0;
            pos_q   <= POS_INI;
            fases_q <= 4'b0000;
            paso_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            fases_q <= fases_d;
            paso_q  <= paso_d;
        end
    end

    assign fases    = fases_q;
    assign posicion = pos_q;
    assign paso     = paso_q;
    assign lim_max  = (pos_q == POS_MAX);
    assign lim_min  = (pos_q == 16'd0);

endmodule

// File: tb/tb_driver_motor_paso.sv
// tb/tb_driver_motor_paso.sv - directed self-checking bench for driver_motor_paso (DIV=4, POS_MAX=5, full-step).
module tb_driver_motor_paso;

    logic        clk = 1'b0;
    logic        rst;
    logic        habilitar;
    logic [1:0]  s_in;
    logic [3:0]  fases;
    logic [15:0] posicion;
    logic        paso;
    logic        lim_max;
    logic        lim_min;

    int n_tests = 0;
    int n_fail  = 0;

    driver_motor_paso #(
        .DIV     (16'd4),
        .POS_MAX (16'd5),
        .POS_INI (16'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .habilitar (habilitar),
        .s_in      (s_in),
        .fases     (fases),
        .posicion  (posicion),
        .paso      (paso),
        .lim_max   (lim_max),
        .lim_min   (lim_min)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs n cycles sampling at negedge: paso must stay low until the last one,
    // where paso, fases and posicion are compared against the hand-computed values.
    task automatic run_check(input string tag, input int n, input logic exp_paso,
                             input logic [3:0] exp_fases, input logic [15:0] exp_pos);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < n - 1) check({tag, "_paso_idle"}, 32'(paso), 32'd0);
        end
        check({tag, "_paso"},  32'(paso),     32'(exp_paso));
        check({tag, "_fases"}, 32'(fases),    32'(exp_fases));
        check({tag, "_pos"},   32'(posicion), 32'(exp_pos));
    endtask

    logic [3:0] fwd_fases [5];
    logic [3:0] rev_fases [5];

    initial begin
        fwd_fases = '{4'b0110, 4'b1100, 4'b1001, 4'b0011, 4'b0110};
        rev_fases = '{4'b0011, 4'b1001, 4'b1100, 4'b0110, 4'b0011};

        rst = 1'b1;
        habilitar = 1'b0;
        s_in = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_fases",   32'(fases),    32'd0);
        check("rst_pos",     32'(posicion), 32'd0);
        check("rst_paso",    32'(paso),     32'd0);
        check("rst_lim_min", 32'(lim_min),  32'd1);
        check("rst_lim_max", 32'(lim_max),  32'd0);

        // Forward run to the upper limit
        rst = 1'b0;
        habilitar = 1'b1;
        s_in = 2'b01;
        run_check("fwd_first", 1, 1'b0, 4'b0011, 16'd0);
        run_check("fwd_s0", 3, 1'b1, fwd_fases[0], 16'd1);
        for (int k = 1; k < 5; k++)
            run_check($sformatf("fwd_s%0d", k), 4, 1'b1, fwd_fases[k], 16'(k + 1));
        run_check("fwd_sat", 4, 1'b0, 4'b0110, 16'd5);
        check("fwd_lim_max", 32'(lim_max), 32'd1);
        check("fwd_lim_min", 32'(lim_min), 32'd0);

        // Reverse run down to zero, wrapping index 0 -> 3
        s_in = 2'b11;
        for (int k = 0; k < 5; k++)
            run_check($sformatf("rev_s%0d", k), 4, 1'b1, rev_fases[k], 16'(4 - k));
        run_check("rev_sat", 4, 1'b0, 4'b0011, 16'd0);
        check("rev_lim_min", 32'(lim_min), 32'd1);

        // Command change mid-period only matters at the tick
        s_in = 2'b01;
        run_check("tog_step", 4, 1'b1, 4'b0110, 16'd1);
        run_check("tog_mid", 2, 1'b0, 4'b0110, 16'd1);
        s_in = 2'b00;
        run_check("tog_stop", 2, 1'b0, 4'b0110, 16'd1);
        s_in = 2'b01;
        run_check("tog_resume", 4, 1'b1, 4'b1100, 16'd2);

        // Disable at posicion 2 / index 2, then re-enable
        habilitar = 1'b0;
        run_check("dis_edge", 1, 1'b0, 4'b0000, 16'd2);
        run_check("dis_hold", 5, 1'b0, 4'b0000, 16'd2);
        habilitar = 1'b1;
        run_check("ena_first", 1, 1'b0, 4'b1100, 16'd2);
        run_check("ena_step", 3, 1'b1, 4'b1001, 16'd3);

        // Asynchronous reset mid-cycle with posicion 3
        #2 rst = 1'b1;
        #1;
        check("arst_fases",   32'(fases),    32'd0);
        check("arst_pos",     32'(posicion), 32'd0);
        check("arst_paso",    32'(paso),     32'd0);
        check("arst_lim_min", 32'(lim_min),  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Reserved command 10 behaves as stop
        s_in = 2'b10;
        run_check("res_first", 1, 1'b0, 4'b0011, 16'd0);
        run_check("res_tick", 3, 1'b0, 4'b0011, 16'd0);
        run_check("res_tick2", 4, 1'b0, 4'b0011, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
